// File: rtl/note_player.sv
// note_player: turns the pattern sequencer's note stream into one timed,
// gated square-wave voice for the mixer/instrument stage.
//
// Handshake: pulses o_note_stb to request a note, waits (indefinitely) for
// i_note_valid, then holds the note for its length in tempo ticks.
// The tone half-period comes from a pitch-to-period table built from CLK_HZ.
//
// Build option: define NOTE_PLAYER_ARTIC_EN for staccato articulation
// (the gate drops one tick early on notes of effective length >= 2).
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_run               play enable level; low returns to idle
//   i_tick              one-cycle tempo tick
//   i_note_valid        sequencer note fields valid
//   i_note_pitch [5:0]  0 = rest, 1..63 = note index pitch-1
//   i_note_len   [4:0]  length in ticks, 0 encodes 32
//   i_note_instrument   instrument number, latched and passed through
//   o_note_stb          one-cycle request for the next note
//   o_gate              voice sounding
//   o_square            square-wave tone
//   o_pitch, o_instrument  latched fields of the current note
module note_player #(
  parameter int unsigned CLK_HZ = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_tick,
  input  logic       i_note_valid,
  input  logic [5:0] i_note_pitch,
  input  logic [4:0] i_note_len,
  input  logic [3:0] i_note_instrument,
  output logic       o_note_stb,
  output logic       o_gate,
  output logic       o_square,
  output logic [5:0] o_pitch,
  output logic [3:0] o_instrument
);

  localparam int unsigned PITCH_W = 6;
  localparam int unsigned INSTR_W = 4;
  localparam int unsigned DUR_W   = 6;
  localparam int unsigned HALF_W  = 18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_PLAY = 2'd3
  } state_t;

  // Half-period in clocks of semitone s in the lowest octave (C1 = 32.7032 Hz).
  function automatic int base_of(input int s);
    real ratio;
    case (s)
      0:       ratio = 1.0;
      1:       ratio = 1.0594630943592953;
      2:       ratio = 1.122462048309373;
      3:       ratio = 1.189207115002721;
      4:       ratio = 1.2599210498948732;
      5:       ratio = 1.3348398541700344;
      6:       ratio = 1.4142135623730951;
      7:       ratio = 1.4983070768766815;
      8:       ratio = 1.5874010519681994;
      9:       ratio = 1.681792830507429;
      10:      ratio = 1.7817974362806785;
      11:      ratio = 1.8877486253633868;
      default: ratio = 1.0;
    endcase
    return $rtoi(real'(CLK_HZ) / (65.4064 * ratio) + 0.5);
  endfunction

  localparam int BASE [12] = '{
    base_of(0), base_of(1), base_of(2),  base_of(3),
    base_of(4), base_of(5), base_of(6),  base_of(7),
    base_of(8), base_of(9), base_of(10), base_of(11)
  };

  state_t              state_q, state_d;
  logic                stb_q, stb_d;
  logic                gate_q, gate_d;
  logic                square_q, square_d;
  logic [PITCH_W-1:0]  pitch_q, pitch_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [HALF_W-1:0]   tone_q, tone_d;
  logic [HALF_W-1:0]   half_q, half_d;

  // Period lookup for the incoming note; only used on the accept cycle.
  logic [PITCH_W-1:0]  note_n;
  logic [3:0]          note_semi;
  logic [2:0]          note_oct;
  logic [HALF_W-1:0]   note_half;
  logic [DUR_W-1:0]    note_dur;

  always_comb begin
    note_n    = PITCH_W'(i_note_pitch - PITCH_W'(1));
    note_semi = 4'(note_n % PITCH_W'(12));
    note_oct  = 3'(note_n / PITCH_W'(12));
    note_half = HALF_W'(BASE[note_semi] >> note_oct);
    note_dur  = (i_note_len == 5'd0) ? DUR_W'(32) : DUR_W'(i_note_len);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      stb_q    <= 1'b0;
      gate_q   <= 1'b0;
      square_q <= 1'b0;
      pitch_q  <= '0;
      instr_q  <= '0;
      dur_q    <= '0;
      tone_q   <= '0;
      half_q   <= '0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      gate_q   <= gate_d;
      square_q <= square_d;
      pitch_q  <= pitch_d;
      instr_q  <= instr_d;
      dur_q    <= dur_d;
      tone_q   <= tone_d;
      half_q   <= half_d;
    end
  end

  // Next-state, duration and tone logic.
  always_comb begin
    state_d  = state_q;
    stb_d    = 1'b0;
    gate_d   = gate_q;
    square_d = square_q;
    pitch_d  = pitch_q;
    instr_d  = instr_q;
    dur_d    = dur_q;
    tone_d   = tone_q;
    half_d   = half_q;

    if (!i_run) begin
      // Stop wins over any coincident tick or valid.
      state_d = S_IDLE;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
          stb_d   = 1'b1;
          gate_d  = 1'b0;
        end
        S_REQ: begin
          state_d = S_WAIT;
          gate_d  = 1'b0;
        end
        S_WAIT: begin
          gate_d = 1'b0;
          if (i_note_valid) begin
            state_d = S_PLAY;
            pitch_d = i_note_pitch;
            instr_d = i_note_instrument;
            dur_d   = note_dur;
            half_d  = note_half;
            gate_d  = (i_note_pitch != '0);
          end
        end
        S_PLAY: begin
          if (i_tick) begin
            if (dur_q == DUR_W'(1)) begin
              state_d = S_REQ;
              stb_d   = 1'b1;
              gate_d  = 1'b0;
            end else begin
              dur_d = DUR_W'(dur_q - DUR_W'(1));
`ifdef NOTE_PLAYER_ARTIC_EN
              // Tick bringing the counter to 1 opens the staccato gap.
              if (dur_q == DUR_W'(2)) begin
                gate_d = 1'b0;
              end
`endif
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          gate_d  = 1'b0;
        end
      endcase
    end

    // Tone runs only while the gate stays high; a rising gate starts from 0.
    if (!gate_d || !gate_q) begin
      tone_d   = '0;
      square_d = 1'b0;
    end else if (tone_q == HALF_W'(half_q - HALF_W'(1))) begin
      tone_d   = '0;
      square_d = ~square_q;
    end else begin
      tone_d = HALF_W'(tone_q + HALF_W'(1));
    end
  end

  assign o_note_stb   = stb_q;
  assign o_gate       = gate_q;
  assign o_square     = square_q;
  assign o_pitch      = pitch_q;
  assign o_instrument = instr_q;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: handshake, durations, tone period, rests,
// stop/restart and reset mid-note. Optional NOTE_PLAYER_ARTIC_EN selects
// the staccato expectations.
module tb_note_player;

  logic       clk;
  logic       rst;
  logic       run;
  logic       tick;
  logic       valid;
  logic [5:0] pitch;
  logic [4:0] len;
  logic [3:0] instr;
  logic       note_stb;
  logic       gate;
  logic       square;
  logic [5:0] out_pitch;
  logic [3:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int HALF58 = 14204;

`ifdef NOTE_PLAYER_ARTIC_EN
  localparam int ARTIC = 1;
`else
  localparam int ARTIC = 0;
`endif

  note_player dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_run             (run),
    .i_tick            (tick),
    .i_note_valid      (valid),
    .i_note_pitch      (pitch),
    .i_note_len        (len),
    .i_note_instrument (instr),
    .o_note_stb        (note_stb),
    .o_gate            (gate),
    .o_square          (square),
    .o_pitch           (out_pitch),
    .o_instrument      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic accept(input logic [5:0] p, input logic [4:0] l, input logic [3:0] ins);
    valid = 1'b1; pitch = p; len = l; instr = ins;
    cyc();
    valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  int hits;

  initial begin
    rst = 1'b1; run = 1'b0; tick = 1'b0; valid = 1'b0;
    pitch = '0; len = '0; instr = '0;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_stb",   int'(note_stb),  0);
    check("rst_gate",  int'(gate),      0);
    check("rst_sq",    int'(square),    0);
    check("rst_pitch", int'(out_pitch), 0);
    check("rst_instr", int'(out_instr), 0);

    // First request and an indefinitely long wait.
    run = 1'b1;
    cyc();
    check("first_stb", int'(note_stb), 1);
    cyc();
    check("stb_one_cycle", int'(note_stb), 0);
    hits = 0;
    repeat (100) begin
      cyc();
      if (note_stb || gate) hits++;
    end
    check("wait_quiet", hits, 0);

    // Note 1: pitch 10, len 3, instrument 5.
    accept(6'd10, 5'd3, 4'd5);
    check("n1_pitch", int'(out_pitch), 10);
    check("n1_instr", int'(out_instr), 5);
    check("n1_gate",  int'(gate),      1);
    cyc(); cyc();
    do_tick();
    check("n1_t1_gate", int'(gate), 1);
    cyc();
    do_tick();
    check("n1_t2_gate", int'(gate), ARTIC ? 0 : 1);
    check("n1_t2_stb",  int'(note_stb), 0);
    check("n1_sq_low",  int'(square), 0);
    cyc();
    do_tick();
    check("n1_end_gate", int'(gate),     0);
    check("n1_end_stb",  int'(note_stb), 1);

    // Note 2: pitch 58 presented two cycles after the strobe; tone period.
    cyc(); cyc();
    accept(6'd58, 5'd1, 4'd2);
    check("n2_gate",  int'(gate),      1);
    check("n2_pitch", int'(out_pitch), 58);
    for (int i = 1; i <= 2 * HALF58; i++) begin
      if (i == 100) valid = 1'b1;
      if (i == 100) pitch = 6'd3;
      cyc();
      valid = 1'b0;
      if (i == HALF58 - 1)     check("sq_before_edge1", int'(square), 0);
      if (i == HALF58)         check("sq_edge1",        int'(square), 1);
      if (i == 2 * HALF58 - 1) check("sq_before_edge2", int'(square), 1);
      if (i == 2 * HALF58)     check("sq_edge2",        int'(square), 0);
    end
    check("play_valid_ignored", int'(out_pitch), 58);
    do_tick();
    check("n2_end_stb",  int'(note_stb), 1);
    check("n2_end_gate", int'(gate),     0);

    // Rest of 32 ticks, with a tick on the accept cycle that must not count.
    cyc(); cyc();
    valid = 1'b1; pitch = 6'd0; len = 5'd0; tick = 1'b1;
    cyc();
    valid = 1'b0; tick = 1'b0;
    hits = 0;
    for (int i = 0; i < 31; i++) begin
      do_tick();
      if (note_stb || gate || square) hits++;
      cyc();
      if (note_stb || gate || square) hits++;
    end
    check("rest_silent", hits, 0);
    do_tick();
    check("rest_end_stb", int'(note_stb), 1);

    // Stop mid-note with a coincident tick, then restart.
    cyc(); cyc();
    accept(6'd20, 5'd5, 4'd1);
    do_tick();
    check("n3_gate", int'(gate), 1);
    run = 1'b0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("stop_gate", int'(gate),     0);
    check("stop_sq",   int'(square),   0);
    check("stop_stb",  int'(note_stb), 0);
    hits = 0;
    valid = 1'b1; pitch = 6'd7;
    repeat (5) begin
      cyc();
      valid = 1'b0;
      if (note_stb || gate) hits++;
    end
    check("idle_quiet", hits, 0);
    run = 1'b1;
    cyc();
    check("restart_stb", int'(note_stb), 1);

    // Reset while playing.
    cyc(); cyc();
    accept(6'd30, 5'd4, 4'd9);
    check("n4_gate", int'(gate), 1);
    rst = 1'b1; valid = 1'b1;
    cyc();
    rst = 1'b0; valid = 1'b0;
    check("rstp_stb",   int'(note_stb),  0);
    check("rstp_gate",  int'(gate),      0);
    check("rstp_sq",    int'(square),    0);
    check("rstp_pitch", int'(out_pitch), 0);
    check("rstp_instr", int'(out_instr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Consumes the note stream produced by the pattern sequencer and turns it into a timed, gated square-wave voice. It drives the sequencer's note strobe to request each note and holds each note for its encoded length in tempo ticks. It generates the tone from a pitch-to-period lookup. It sits between the pattern sequencer and the per-voice mixer/instrument stage.

## Interface
- `CLK_HZ`, default 25_000_000: system clock frequency, used to build the period table.
- `i_clk`  in  1: system clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_run`  in  1: level signal. High means play; low means stop and go idle.
- `i_tick`  in  1: one-cycle tempo tick strobe.
- `i_note_valid`  in  1: sequencer note fields are valid.
- `i_note_pitch`  in  6: 0 is a rest; 1..63 is note index n = pitch−1.
- `i_note_len`  in  5: note length in ticks; 0 encodes 32.
- `i_note_instrument`  in  4: instrument number, passed through.
- `o_note_stb`  out  1: one-cycle request for the next note.
- `o_gate`  out  1: the voice is sounding.
- `o_square`  out  1: tone output.
- `o_pitch`  out  6: latched pitch of the current note.
- `o_instrument`  out  4: latched instrument of the current note.

## Operation
- States:
  - IDLE → REQ when `i_run`=1.
  - REQ → WAIT unconditionally. REQ lasts exactly one cycle.
  - WAIT → PLAY on the first cycle with `i_note_valid`=1.
  - PLAY → REQ when the duration expires.
- Any state → IDLE in the cycle after `i_run`=0. In that cycle `o_gate`=0 and `o_square`=0. A pending WAIT is abandoned.
- `o_note_stb` is high only while in REQ.
- `i_note_valid` is ignored outside WAIT.
- Accept (WAIT with valid):
  - Latch pitch and instrument.
  - Load the duration counter with len (0→32), 6 bits.
  - Clear the tone counter and set `o_square`=0.
- Duration:
  - Each `i_tick` in PLAY decrements the counter.
  - A tick seen while the counter is 1 ends the note.
  - A tick coinciding with the accept cycle is ignored.
- Gate:
  - `o_gate`=1 in PLAY when pitch≠0, otherwise 0.
  - A rest still consumes its duration.
- Period:
  - s = n mod 12, oct = n div 12 (0..5).
  - half = BASE[s] >> oct, 18 bits, truncating.
  - BASE[s] = round(CLK_HZ / (2·32.7032·2^(s/12))), evaluated at elaboration.
  - With the default CLK_HZ, BASE[9] = 227273.
- Tone:
  - While gate is high, the tone counter increments every cycle.
  - At count = half−1, `o_square` toggles and the counter clears.
  - While gate is low, the counter is held at 0 and `o_square`=0.

## Timing
- Reset values: state IDLE; `o_note_stb`, `o_gate`, `o_square` = 0; `o_pitch`, `o_instrument` = 0; all counters 0.
- Reset mid-note has the same effect: all outputs return to zero on the next cycle.
- All outputs are registered.
- `i_run` rises in cycle t → `o_note_stb`=1 in t+1 only.
- `i_note_valid` is seen in WAIT at cycle t → PLAY, `o_gate`, and `o_pitch` are updated at t+1.
- The ending tick is at cycle t → `o_gate`=0 and `o_note_stb`=1 at t+1.
- Sequencer read latency is unbounded. WAIT holds indefinitely with the gate low.
- The first `o_square` edge comes half cycles after the gate rises.
- Full square period is 2·half cycles.
- `i_run`=0 in the same cycle as the note-end tick or as valid → IDLE wins.

## Configuration
- `NOTE_PLAYER_ARTIC_EN` defined: staccato articulation.
  - For notes with effective length ≥2, `o_gate` drops after the tick that brings the counter to 1.
  - This gives a one-tick silent gap at the end of the note.
  - Tone output follows the gate.
- Undefined: the gate stays high for the full length.
- Strobe timing is identical in both builds.

## Test plan
- Reset then `i_run`=1: exactly one `o_note_stb` pulse, one cycle after `i_run` rises. No second pulse while no valid arrives for 100 cycles.
- Note (pitch 10, len 3, instr 5) with valid 2 cycles after the strobe:
  - `o_pitch`=10, `o_instrument`=5, gate high one cycle later.
  - Gate drops and the next strobe fires one cycle after the 3rd tick.
  - With `NOTE_PLAYER_ARTIC_EN`, the gate drops one cycle after the 2nd tick instead.
- Pitch 58 at default CLK_HZ: half = 14204, and `o_square` toggles every 14204 cycles. Pitch 10: toggles every 227273 cycles.
- Rest (pitch 0, len 0): gate and square stay 0 for 32 ticks, then a strobe fires. A tick on the accept cycle is not counted.
- `i_run` dropped mid-note with a coincident tick: IDLE next cycle, all tone outputs 0, no strobe. `i_run` reasserted → a fresh strobe follows.
- `i_rst` asserted during PLAY: every output is 0 next cycle. `i_note_valid` pulsing in IDLE or PLAY is ignored.
